// File: rtl/lcd_instr_tx_fsm.sv
// Sends one 10-bit LCD instruction over the 4-bit bus as two strobed nibbles,
// waits out the execution time, then pulses done for a single cycle.
module lcd_instr_tx_fsm #(
    parameter int T_SETUP  = 2,
    parameter int T_EPULSE = 12,
    parameter int T_HOLD   = 1,
    parameter int T_GAP    = 50,
    parameter int T_WAIT   = 2000,
    parameter int CNT_W    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_fsm_enable,
    input  logic [9:0] instruction,
    output logic       instr_fsm_done,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_UP_SETUP = 4'd1,
        S_UP_E     = 4'd2,
        S_UP_HOLD  = 4'd3,
        S_GAP      = 4'd4,
        S_LO_SETUP = 4'd5,
        S_LO_E     = 4'd6,
        S_LO_HOLD  = 4'd7,
        S_WAIT     = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_EPULSE = CNT_W'(T_EPULSE - 1);
    localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] L_WAIT   = CNT_W'(T_WAIT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            // Counter restarts on every state change and idles at zero.
            if (w_state_next != r_state || r_state == S_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE && instr_fsm_enable)
                r_instr <= instruction;
        end
    end

    always_comb begin
        w_state_next   = S_IDLE;
        instr_fsm_done = 1'b0;
        busy           = 1'b0;
        lcd_e          = 1'b0;
        lcd_rs         = 1'b0;
        lcd_rw         = 1'b0;
        lcd_db         = 4'h0;
        case (r_state)
            S_IDLE: begin
                w_state_next = instr_fsm_enable ? S_UP_SETUP : S_IDLE;
            end
            S_UP_SETUP: begin
                w_state_next = (r_cnt == L_SETUP) ? S_UP_E : S_UP_SETUP;
                busy   = 1'b1;
                lcd_rs = r_instr[9];
                lcd_rw = r_instr[8];
                lcd_db = r_instr[7:4];
            end
            S_UP_E: begin
                w_state_next = (r_cnt == L_EPULSE) ? S_UP_HOLD : S_UP_E;
                busy   = 1'b1;
                lcd_e  = 1'b1;
                lcd_rs = r_instr[9];
                lcd_rw = r_instr[8];
                lcd_db = r_instr[7:4];
            end
            S_UP_HOLD: begin
                w_state_next = (r_cnt == L_HOLD) ? S_GAP : S_UP_HOLD;
                busy   = 1'b1;
                lcd_rs = r_instr[9];
                lcd_rw = r_instr[8];
                lcd_db = r_instr[7:4];
            end
            S_GAP: begin
                w_state_next = (r_cnt == L_GAP) ? S_LO_SETUP : S_GAP;
                busy   = 1'b1;
                lcd_rs = r_instr[9];
                lcd_rw = r_instr[8];
            end
            S_LO_SETUP: begin
                w_state_next = (r_cnt == L_SETUP) ? S_LO_E : S_LO_SETUP;
                busy   = 1'b1;
                lcd_rs = r_instr[9];
                lcd_rw = r_instr[8];
                lcd_db = r_instr[3:0];
            end
            S_LO_E: begin
                w_state_next = (r_cnt == L_EPULSE) ? S_LO_HOLD : S_LO_E;
                busy   = 1'b1;
                lcd_e  = 1'b1;
                lcd_rs = r_instr[9];
                lcd_rw = r_instr[8];
                lcd_db = r_instr[3:0];
            end
            S_LO_HOLD: begin
                w_state_next = (r_cnt == L_HOLD) ? S_WAIT : S_LO_HOLD;
                busy   = 1'b1;
                lcd_rs = r_instr[9];
                lcd_rw = r_instr[8];
                lcd_db = r_instr[3:0];
            end
            S_WAIT: begin
                w_state_next = (r_cnt == L_WAIT) ? S_DONE : S_WAIT;
                busy = 1'b1;
            end
            S_DONE: begin
                w_state_next   = S_IDLE;
                busy           = 1'b1;
                instr_fsm_done = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_instr_tx_fsm.sv
// Directed and randomized transactions checked cycle by cycle against a
// timeline model derived from the per-state durations.
module tb_lcd_instr_tx_fsm;

    localparam int TS = 2, TE = 12, TH = 1, TG = 50, TW = 2000, CW = 12;
    // Cycle offsets of each phase, counting the enable-sample cycle as 0.
    localparam int C_UE = 1 + TS;
    localparam int C_UH = C_UE + TE;
    localparam int C_GP = C_UH + TH;
    localparam int C_L0 = C_GP + TG;
    localparam int C_LE = C_L0 + TS;
    localparam int C_LH = C_LE + TE;
    localparam int C_W  = C_LH + TH;
    localparam int C_D  = C_W + TW;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_fsm_enable = 1'b0;
    logic [9:0] instruction = '0;
    logic       instr_fsm_done, busy, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_db;

    int vectors = 0;
    int miscompares = 0;

    lcd_instr_tx_fsm #(
        .T_SETUP(TS), .T_EPULSE(TE), .T_HOLD(TH), .T_GAP(TG), .T_WAIT(TW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .instr_fsm_enable(instr_fsm_enable), .instruction(instruction),
        .instr_fsm_done(instr_fsm_done), .busy(busy),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
    );

    always #10 clk = ~clk;

    // Packed as {done, busy, e, rs, rw, db[3:0]}.
    function automatic logic [8:0] model(input int k, input logic [9:0] ins);
        logic up, lo, ctl, e, bsy, dn;
        logic [3:0] db;
        up  = (k >= 1) && (k < C_GP);
        lo  = (k >= C_L0) && (k < C_W);
        ctl = (k >= 1) && (k < C_W);
        e   = ((k >= C_UE) && (k < C_UH)) || ((k >= C_LE) && (k < C_LH));
        bsy = (k >= 1) && (k <= C_D);
        dn  = (k == C_D);
        db  = up ? ins[7:4] : (lo ? ins[3:0] : 4'h0);
        return {dn, bsy, e, ctl & ins[9], ctl & ins[8], db};
    endfunction

    function automatic logic [8:0] observed();
        return {instr_fsm_done, busy, lcd_e, lcd_rs, lcd_rw, lcd_db};
    endfunction

    task automatic check(input string tag, input int k, input logic [8:0] exp);
        logic [8:0] obs;
        obs = observed();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Entered during cycle 0 with enable/instruction already driven.
    task automatic do_txn(input string tag, input logic [9:0] ins, input bit noise,
                          input bit chain, input logic [9:0] nxt, input int abort_k);
        @(negedge clk);
        check(tag, 0, model(0, ins));
        for (int k = 1; k <= C_D; k++) begin
            @(posedge clk); #1;
            if (k == abort_k) begin
                check({tag, "_pre_abort"}, k, model(k, ins));
                reset = 1'b1;
                instr_fsm_enable = 1'b0;
                #1 check({tag, "_abort_async"}, k, 9'h0);
                repeat (2) begin
                    @(negedge clk);
                    check({tag, "_abort_hold"}, k, 9'h0);
                end
                @(posedge clk); #1;
                reset = 1'b0;
                #1 check({tag, "_abort_release"}, k, 9'h0);
                return;
            end
            if (k == C_D) begin
                instr_fsm_enable = chain;
                instruction = chain ? nxt : 10'($urandom);
            end else if (noise) begin
                instr_fsm_enable = 1'($urandom);
                instruction = 10'($urandom);
            end else begin
                instr_fsm_enable = 1'b0;
            end
            @(negedge clk);
            check(tag, k, model(k, ins));
        end
        if (!chain) begin
            @(posedge clk); #1;
            check({tag, "_idle"}, C_D + 1, 9'h0);
        end
        $display("txn %s instr=%h noise=%0d chain=%0d vectors=%0d miscompares=%0d",
                 tag, ins, noise, chain, vectors, miscompares);
    endtask

    task automatic start(input logic [9:0] ins);
        instr_fsm_enable = 1'b1;
        instruction = ins;
    endtask

    initial begin
        logic [9:0] r;
        // Reset held with an active request: outputs must stay quiet.
        instr_fsm_enable = 1'b1;
        instruction = 10'h3FF;
        repeat (3) begin
            @(negedge clk);
            check("reset", 0, 9'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        do_txn("after_reset", 10'h3FF, 1'b0, 1'b0, 10'h0, 0);

        start(10'h028);
        do_txn("function_set", 10'h028, 1'b0, 1'b0, 10'h0, 0);

        start(10'b10_0100_0001);
        do_txn("data_A", 10'b10_0100_0001, 1'b0, 1'b0, 10'h0, 0);

        start(10'h006);
        do_txn("input_noise", 10'h006, 1'b1, 1'b0, 10'h0, 0);

        r = 10'($urandom);
        start(r);
        do_txn("abort", r, 1'b0, 1'b0, 10'h0, 70);
        start(10'h001);
        do_txn("post_abort", 10'h001, 1'b0, 1'b0, 10'h0, 0);

        start(10'h028);
        do_txn("b2b_first", 10'h028, 1'b0, 1'b1, 10'h006, 0);
        do_txn("b2b_second", 10'h006, 1'b0, 1'b0, 10'h0, 0);

        for (int i = 0; i < 3; i++) begin
            r = 10'($urandom);
            start(r);
            do_txn("random", r, 1'b1, 1'b0, 10'h0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
